// File: rtl/rv32i_instr_encoder_pkg.sv
// rtl/rv32i_instr_encoder_pkg.sv - shared RV32I opcode, format and status definitions
// Purpose: constants and types shared by the encoder and the core's decoder.
// Contents: opcode constants, format enum, NOP word, err_code values,
//           S1 field bundle and the opcode -> format classifier.
package rv32i_instr_encoder_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;

  // Fields held in stage 1, already classified.
  typedef struct packed {
    logic [6:0]  fn7;
    logic [2:0]  fn3;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        shift;
  } s1_t;

  function automatic fmt_e classify(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                              f = FMT_S;
      OP_REG:                                f = FMT_R;
      OP_LUI, OP_AUIPC:                      f = FMT_U;
      OP_BRANCH:                             f = FMT_B;
      OP_JAL:                                f = FMT_J;
      default:                               f = FMT_BAD;
    endcase
    return f;
  endfunction

  // slli / srli / srai: the immediate slot carries fn7 + shamt.
  function automatic logic is_shift(input logic [6:0] opc, input logic [2:0] fn3);
    return (opc == OP_IMM) && (fn3[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// rtl/rv32i_imm_pack.sv - places immediate bits at their RV32I instruction positions
// Purpose: combinational format + immediate -> immediate bits in instruction
//          position (all other bits zero), plus a range-violation flag.
// Ports: i_fmt (format), i_shift (shift-immediate form), i_imm (byte offset /
//        shamt), o_imm_bits (positioned bits), o_range_err (immediate unencodable).
// Macro: ENCODER_RANGE_CHECK_EN enables the range check; otherwise o_range_err
//        is tied low and excess bits are truncated.
module rv32i_imm_pack
  import rv32i_instr_encoder_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic        i_shift,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_range_err
);

  always_comb begin
    o_imm_bits = '0;
    case (i_fmt)
      FMT_I:   o_imm_bits = i_shift ? {7'b0, i_imm[4:0], 20'b0}
                                    : {i_imm[11:0], 20'b0};
      FMT_S:   o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
      FMT_B:   o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
      FMT_U:   o_imm_bits = {i_imm[31:12], 12'b0};
      FMT_J:   o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
      default: o_imm_bits = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // A value fits N signed bits when bits [31:N-1] are all equal.
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;

  assign w_fits12 = (~|i_imm[31:11]) | (&i_imm[31:11]);
  assign w_fits13 = (~|i_imm[31:12]) | (&i_imm[31:12]);
  assign w_fits21 = (~|i_imm[31:20]) | (&i_imm[31:20]);

  always_comb begin
    o_range_err = 1'b0;
    case (i_fmt)
      FMT_I:   o_range_err = i_shift ? (|i_imm[31:5]) : !w_fits12;
      FMT_S:   o_range_err = !w_fits12;
      FMT_B:   o_range_err = !w_fits13 || i_imm[0];
      FMT_J:   o_range_err = !w_fits21 || i_imm[0];
      FMT_U:   o_range_err = |i_imm[11:0];
      default: o_range_err = 1'b0;
    endcase
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - two-stage pipelined RV32I instruction encoder
// Purpose: packs decoded fields into 32-bit instruction words and streams them
//          with a word address to instruction memory.
// Ports: clk, rst_n (async active-low), clear (sync flush/restart),
//        in_valid/in_ready + op_code/rd_sel/rs1_sel/rs2_sel/imm (input side),
//        out_valid/out_ready + instr/instr_addr/err_code (output side),
//        err (sticky error).
// Macro: ENCODER_RANGE_CHECK_EN (immediate range checking, see rv32i_imm_pack).
module rv32i_instr_encoder
  import rv32i_instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       op_code,
  input  logic [4:0]        rd_sel,
  input  logic [4:0]        rs1_sel,
  input  logic [4:0]        rs2_sel,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

  // op_code bit 9 is fn3[2]. fn7[0] is zero in every RV32I encoding, so only
  // fn7[6:1] is carried in op_code[15:10].
  logic [6:0] w_fn7;
  logic [2:0] w_fn3;
  logic [6:0] w_opc;
  s1_t        w_s1_next;

  assign w_fn7 = {op_code[15:10], 1'b0};
  assign w_fn3 = op_code[9:7];
  assign w_opc = op_code[6:0];

  always_comb begin
    w_s1_next        = '0;
    w_s1_next.fn7    = w_fn7;
    w_s1_next.fn3    = w_fn3;
    w_s1_next.opcode = w_opc;
    w_s1_next.rd     = rd_sel;
    w_s1_next.rs1    = rs1_sel;
    w_s1_next.rs2    = rs2_sel;
    w_s1_next.imm    = imm;
    w_s1_next.fmt    = classify(w_opc);
    w_s1_next.shift  = is_shift(w_opc, w_fn3);
  end

  s1_t              r_s1;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [31:0]      r_instr;
  logic [1:0]       r_err_code;
  logic [ADDR_W-1:0] r_addr;
  logic             r_err;

  logic w_out_fire;
  logic w_s2_load_ok;
  logic w_in_fire;

  assign w_out_fire   = r_s2_valid && out_ready;
  assign w_s2_load_ok = !r_s2_valid || out_ready;
  assign in_ready     = !r_s1_valid || w_s2_load_ok;
  assign w_in_fire    = in_valid && in_ready;

  // Stage 1 -> stage 2 packing
  logic [31:0] w_imm_bits;
  logic        w_range_err;
  logic [31:0] w_fields;
  logic [31:0] w_next_instr;
  logic [1:0]  w_next_code;

  rv32i_imm_pack u_imm_pack (
    .i_fmt       (r_s1.fmt),
    .i_shift     (r_s1.shift),
    .i_imm       (r_s1.imm),
    .o_imm_bits  (w_imm_bits),
    .o_range_err (w_range_err)
  );

  // Register/function fields for each layout; immediate bits are OR-ed in.
  always_comb begin
    w_fields = '0;
    case (r_s1.fmt)
      FMT_R:   w_fields = {r_s1.fn7, r_s1.rs2, r_s1.rs1, r_s1.fn3, r_s1.rd, r_s1.opcode};
      FMT_I:   w_fields = r_s1.shift
                          ? {r_s1.fn7, 5'b0, r_s1.rs1, r_s1.fn3, r_s1.rd, r_s1.opcode}
                          : {12'b0, r_s1.rs1, r_s1.fn3, r_s1.rd, r_s1.opcode};
      FMT_S,
      FMT_B:   w_fields = {7'b0, r_s1.rs2, r_s1.rs1, r_s1.fn3, 5'b0, r_s1.opcode};
      FMT_U,
      FMT_J:   w_fields = {20'b0, r_s1.rd, r_s1.opcode};
      default: w_fields = '0;
    endcase
  end

  always_comb begin
    w_next_instr = w_fields | w_imm_bits;
    w_next_code  = ERR_OK;
    if (r_s1.fmt == FMT_BAD) begin
      w_next_instr = NOP_INSTR;
      w_next_code  = ERR_OPCODE;
    end else if (w_range_err) begin
      w_next_instr = NOP_INSTR;
      w_next_code  = ERR_RANGE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_err_code <= ERR_OK;
      r_addr     <= L_BASE;
      r_err      <= 1'b0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_addr     <= L_BASE;
      r_err      <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1 <= w_s1_next;
      end
      // S1 either refills or empties whenever it is free to move.
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_load_ok) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_instr    <= w_next_instr;
          r_err_code <= w_next_code;
        end
      end
      if (w_out_fire) begin
        r_addr <= r_addr + 1'b1;
        if (r_err_code != ERR_OK) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign instr      = r_instr;
  assign instr_addr = r_addr;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - scoreboard bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

  localparam int ADDR_W = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       op_code = '0;
  logic [4:0]        rd_sel = '0;
  logic [4:0]        rs1_sel = '0;
  logic [4:0]        rs2_sel = '0;
  logic [31:0]       imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              err;
  logic [1:0]        err_code;

  rv32i_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_code    (op_code),
    .rd_sel     (rd_sel),
    .rs1_sel    (rs1_sel),
    .rs2_sel    (rs2_sel),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .instr_addr (instr_addr),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  logic [33:0]       exp_q[$];
  logic [33:0]       exp_e;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_err = 1'b0;
  int                last_hs = 0;
  int                prev_hs = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // Monitor: outputs are sampled at negedge, midway between driving points.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear) begin
        exp_q.delete();
        exp_addr = '0;
        exp_err  = 1'b0;
      end else begin
        if (out_valid && !out_ready && exp_q.size() != 0) begin
          check("stall_instr", 64'(instr), 64'(exp_q[0][31:0]));
          check("stall_addr", 64'(instr_addr), 64'(exp_addr));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(instr), 64'(NOP) ^ 64'(instr) ^ 64'h1_0000_0000);
          end else begin
            exp_e = exp_q.pop_front();
            check("instr", 64'(instr), 64'(exp_e[31:0]));
            check("err_code", 64'(err_code), 64'(exp_e[33:32]));
            check("instr_addr", 64'(instr_addr), 64'(exp_addr));
            check("err_before_hs", 64'(err), 64'(exp_err));
            if (exp_e[33:32] != 2'b00) exp_err = 1'b1;
          end
          exp_addr = exp_addr + 1'b1;
          prev_hs  = last_hs;
          last_hs  = cyc;
        end
      end
    end
  end

  // Driver: called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] op, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [31:0] im,
                      input logic [31:0] exp_i, input logic [1:0] exp_c);
    int t = 0;
    op_code  = op;
    rd_sel   = rd;
    rs1_sel  = r1;
    rs2_sel  = r2;
    imm      = im;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_c, exp_i});
        break;
      end
      t++;
      if (t > 50) begin
        timeout_fail("send_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'(NOP));
    check("rst_addr", 64'(instr_addr), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    @(posedge clk);
    #1;

    // ADDI x1,x0,5 and its two-edge latency
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'b00);
    @(negedge clk);
    check("addi_lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("addi_lat_edge2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();

    // SUB x3,x1,x2 then BEQ x1,x2,-8 back to back
    send(16'h4033, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 2'b00);
    send(16'h0063, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'b00);
    drain();
    check("b2b_consecutive", 64'(last_hs - prev_hs), 64'd1);

    // JAL x1,+2048; SRAI x1,x1,3 (fn3=101 => op_code bit 9 set) is the fifth word
    send(16'h006F, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 2'b00);
    send(16'h4293, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 2'b00);
    drain();
    check("wrap_addr_after_5", 64'(instr_addr), 64'd1);

    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;

    // Backpressure: out_ready low for 5 edges while 4 words are offered
    out_ready = 1'b0;
    fork
      begin
        send(16'h0013, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 2'b00);
        send(16'h0123, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 2'b00);
        send(16'h0093, 5'd4, 5'd1, 5'd0, 32'd31, 32'h01F0_9213, 2'b00);
        send(16'h0037, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 2'b00);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Range and opcode errors
`ifdef ENCODER_RANGE_CHECK_EN
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'h0000_1000, NOP, 2'b10);
`else
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_0093, 2'b00);
`endif
    send(16'h007F, 5'd1, 5'd2, 5'd3, 32'd0, NOP, 2'b01);
    drain();
    check("err_sticky", 64'(err), 64'd1);

    // clear with two words in flight and an input offered
    out_ready = 1'b0;
    send(16'h0013, 5'd6, 5'd0, 5'd0, 32'd1, 32'h0010_0313, 2'b00);
    send(16'h0013, 5'd7, 5'd0, 5'd0, 32'd2, 32'h0020_0393, 2'b00);
    clear    = 1'b1;
    in_valid = 1'b1;
    op_code  = 16'h0013;
    rd_sel   = 5'd9;
    imm      = 32'd9;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_addr", 64'(instr_addr), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'b00);
    drain();
    check("post_clr_addr", 64'(instr_addr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
